instruction_fetch_tag: RTL

First instruction-fetch stage (IFT): owns the program counter and the I$ tag/valid arrays. Each cycle it issues one word-aligned PC, reads all ways' tags and valid bits for that PC's set, and hands PC, tags and valid bits to instruction_fetch_data (IFD) one cycle later. It stalls on IFD-reported misses, installs refilled tags, resumes on IFD's `resume_fetch`, and redirects on writeback branches.

---
 rtl/instruction_fetch_tag_pkg.sv | 44 ++++
 rtl/bram_1r1w.sv | 22 ++
 rtl/instruction_fetch_tag.sv | 129 ++++++++++++
 3 files changed

// File: rtl/instruction_fetch_tag_pkg.sv
// Shared types and sizing for the instruction-fetch tag stage and its IFD handshake.
package instruction_fetch_tag_pkg;

    localparam int ICACHE_NUM_WAYS     = 4;
    localparam int ICACHE_NUM_WAY_BITS = $clog2(ICACHE_NUM_WAYS);
    localparam int ICACHE_NUM_SET_BITS = 6;
    localparam int ICACHE_NUM_SETS     = 1 << ICACHE_NUM_SET_BITS;
    localparam int ICACHE_LINE_BITS    = 5;
    localparam int ICACHE_TAG_BITS     = 32 - ICACHE_NUM_SET_BITS - ICACHE_LINE_BITS;

    typedef logic [ICACHE_TAG_BITS-1:0] icache_tag_t;

    typedef struct packed {
        icache_tag_t                    tag;
        logic [ICACHE_NUM_SET_BITS-1:0] set_idx;
        logic [ICACHE_LINE_BITS-1:0]    offset;
    } ifu_address_t;

    typedef struct packed {
        ifu_address_t                     fetched_pc;
        icache_tag_t [ICACHE_NUM_WAYS-1:0] tags_read;
        logic [ICACHE_NUM_WAYS-1:0]       valid_bits;
    } ift_ifd_inf_t;

    typedef struct packed {
        logic                           cache_miss;
        logic                           resume_fetch;
        logic [ICACHE_NUM_WAYS-1:0]     update_tag_en;
        logic [ICACHE_NUM_SET_BITS-1:0] update_tag_set;
        icache_tag_t                    update_tag;
    } ifd_ift_inf_t;

    typedef enum logic {
        FETCH       = 1'b0,
        WAIT_REFILL = 1'b1
    } ift_state_t;

    function automatic ifu_address_t pc_plus4(input ifu_address_t pc);
        logic [31:0] sum;
        sum = pc + 32'd4;
        return sum;
    endfunction

endpackage

// File: rtl/bram_1r1w.sv
// Block RAM with one synchronous read port and one write port; contents are not reset.
module bram_1r1w #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instruction_fetch_tag.sv
// IFT stage: owns the PC, looks up I$ tags/valid bits, stalls on miss, redirects on branch.
// Build option: define ICACHE_FLUSH_EN to add the icache_flush port and flush behaviour.
//
// state       | meaning
// FETCH       | issue one PC per cycle, advance by 4
// WAIT_REFILL | miss outstanding; no reads until IFD raises resume_fetch
module instruction_fetch_tag
    import instruction_fetch_tag_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_do_branch,
    input  logic [31:0]  wb_branch_target,
    input  ifd_ift_inf_t ifd_ift_inf,
`ifdef ICACHE_FLUSH_EN
    input  logic         icache_flush,
`endif
    output logic         ift_valid,
    output ift_ifd_inf_t ift_ifd_inf
);

    ift_state_t   state_reg, state_next;
    ifu_address_t pc_reg, pc_next;
    ifu_address_t fetched_pc_reg;
    logic         issue, ift_valid_next, flush;

    logic [ICACHE_NUM_WAYS-1:0]                      valid_rd, valid_bits_reg;
    logic [ICACHE_NUM_WAYS-1:0][ICACHE_NUM_SETS-1:0] valid_arr;
    icache_tag_t [ICACHE_NUM_WAYS-1:0]               tags_rd;

`ifdef ICACHE_FLUSH_EN
    assign flush = icache_flush;
`else
    assign flush = 1'b0;
`endif

    for (genvar w = 0; w < ICACHE_NUM_WAYS; w++) begin : g_way
        bram_1r1w #(
            .ADDR_WIDTH(ICACHE_NUM_SET_BITS),
            .DATA_WIDTH(ICACHE_TAG_BITS)
        ) u_tag_ram (
            .clk    (clk),
            .rd_en  (issue),
            .rd_addr(pc_reg.set_idx),
            .rd_data(tags_rd[w]),
            .wr_en  (ifd_ift_inf.update_tag_en[w]),
            .wr_addr(ifd_ift_inf.update_tag_set),
            .wr_data(ifd_ift_inf.update_tag)
        );
    end

    always_comb begin
        valid_rd = '0;
        for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
            valid_rd[w] = valid_arr[w][pc_reg.set_idx];
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        issue          = 1'b0;
        ift_valid_next = 1'b0;
        case (state_reg)
            FETCH: begin
                if (ift_valid && ifd_ift_inf.cache_miss) begin
                    // The in-flight read is dropped; refetch starts from the missed PC.
                    pc_next    = fetched_pc_reg;
                    state_next = WAIT_REFILL;
                end else if (!flush) begin
                    issue          = 1'b1;
                    ift_valid_next = 1'b1;
                    pc_next        = pc_plus4(pc_reg);
                end
            end
            WAIT_REFILL: begin
                if (ifd_ift_inf.resume_fetch) begin
                    issue          = 1'b1;
                    ift_valid_next = 1'b1;
                    pc_next        = pc_plus4(pc_reg);
                    state_next     = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        if (wb_do_branch) begin
            pc_next        = wb_branch_target;
            issue          = 1'b0;
            ift_valid_next = 1'b0;
            state_next     = (state_reg == WAIT_REFILL && ifd_ift_inf.resume_fetch) ? FETCH : state_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            ift_valid      <= 1'b0;
            fetched_pc_reg <= RESET_PC;
            valid_bits_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ift_valid <= ift_valid_next;
            if (issue) begin
                fetched_pc_reg <= pc_reg;
                valid_bits_reg <= valid_rd;
            end
        end
    end

    // Flush wins over a coincident refill install.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_arr <= '0;
        end else begin
            for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
                if (ifd_ift_inf.update_tag_en[w]) valid_arr[w][ifd_ift_inf.update_tag_set] <= 1'b1;
            end
        end
    end

    assign ift_ifd_inf.fetched_pc = fetched_pc_reg;
    assign ift_ifd_inf.tags_read  = tags_rd;
    assign ift_ifd_inf.valid_bits = valid_bits_reg;

endmodule
